// File: rtl/mem_req_arbiter.sv
// Round-robin request arbiter with starvation override, feeding a one-entry
// output register on the memory controller's request port. Also exposes a
// fire strobe, per-request ID, a free-running cycle count and a drop counter
// for the traffic-statistics loggers.
//
// Handshake: a transfer happens on any edge where valid & ready are both high.
// Requesters: in_ready is one-hot (the winner) or zero and is only raised when
// the output register can take a new entry; valid need not wait for ready.
// Downstream: out_valid stays high and the payload stays stable until
// out_valid & out_ready (req_fire); a new entry may load on the firing edge.
module mem_req_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 16,
    parameter int WAIT_W       = 5,
    localparam int SRC_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS-1:0]          in_rd_en,
    input  logic [NUM_PORTS-1:0]          in_wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_rd_en,
    output logic                          out_wr_en,
    output logic [ADDR_W-1:0]             out_addr,
    output logic [SRC_W-1:0]              out_src,
    output logic [31:0]                   out_req_id,
    output logic                          req_fire,
    output logic [63:0]                   global_cycle,
    output logic [15:0]                   err_drop_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic [WAIT_W-1:0]   r_wait [NUM_PORTS];
    logic                r_rd_en;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [SRC_W-1:0]    r_src;
    logic [31:0]         r_req_id;
    logic [63:0]         r_cycle;
    logic [15:0]         r_err_cnt;

    logic                w_can_load;
    logic                w_fire;
    logic                w_gnt_any;
    logic [SRC_W-1:0]    w_gnt_idx;
    logic [SRC_W-1:0]    w_idx;
    logic [NUM_PORTS-1:0] w_starved;
    logic                w_xfer;
    logic                w_wellformed;
    logic                w_sel_rd;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;

    // The output register state is the downstream valid.
    assign out_valid    = (r_state == ST_FULL);
    assign out_rd_en    = r_rd_en;
    assign out_wr_en    = r_wr_en;
    assign out_addr     = r_addr;
    assign out_src      = r_src;
    assign out_req_id   = r_req_id;
    assign global_cycle = r_cycle;
    assign err_drop_cnt = r_err_cnt;

    assign w_fire       = out_valid & out_ready;
    assign req_fire     = w_fire;
    assign w_can_load   = ~out_valid | out_ready;
    assign w_xfer       = w_can_load & w_gnt_any;
    assign w_wellformed = w_sel_rd ^ w_sel_wr;

    // Winner selection: lowest-index starved port first, else round-robin from r_rr_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_starved = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_starved[i] = in_valid[i] && (r_wait[i] >= WAIT_W'(STARVE_LIMIT));
        end
        if (|w_starved) begin
            w_gnt_any = 1'b1;
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (w_starved[i]) w_gnt_idx = SRC_W'(i);
            end
        end else begin
            // Descending scan so the smallest offset from the pointer is kept last.
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                w_idx = r_rr_ptr + SRC_W'(k);
                if (in_valid[w_idx]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_idx;
                end
            end
        end
    end

    // One-hot accept for the winner, and payload mux from the winning port.
    always_comb begin
        in_ready   = '0;
        w_sel_rd   = 1'b0;
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        if (w_xfer) in_ready[w_gnt_idx] = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_gnt_idx == SRC_W'(i)) begin
                w_sel_rd   = in_rd_en[i];
                w_sel_wr   = in_wr_en[i];
                w_sel_addr = in_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Output register next state: a well-formed transfer loads, otherwise a fire empties.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (w_xfer && w_wellformed) begin
            w_state_nxt = ST_FULL;
            w_load      = 1'b1;
        end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Output register state and payload; reset discards any held request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_rd_en <= w_sel_rd;
                r_wr_en <= w_sel_wr;
                r_addr  <= w_sel_addr;
                r_src   <= w_gnt_idx;
            end
        end
    end

    // Round-robin pointer, request ID, cycle count and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_req_id  <= '0;
            r_cycle   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_xfer) r_rr_ptr <= w_gnt_idx + SRC_W'(1);
            if (w_fire) r_req_id <= r_req_id + 32'd1;
            if (w_xfer && !w_wellformed && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    // Per-port wait counters; they keep aging while the output is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!in_valid[i] || in_ready[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != {WAIT_W{1'b1}}) begin
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: stimulus pushes expected downstream
// requests into a queue, a negedge monitor pops and compares on every fire.
module tb_mem_req_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int SW = 2;
    localparam int W  = SW + 2 + AW + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [NP-1:0]     in_rd_en;
    logic [NP-1:0]     in_wr_en;
    logic [NP*AW-1:0]  in_addr;
    logic              out_valid;
    logic              out_ready;
    logic              out_rd_en;
    logic              out_wr_en;
    logic [AW-1:0]     out_addr;
    logic [SW-1:0]     out_src;
    logic [31:0]       out_req_id;
    logic              req_fire;
    logic [63:0]       global_cycle;
    logic [15:0]       err_drop_cnt;

    logic [W-1:0]      exp_q[$];
    logic [31:0]       exp_id = '0;
    int                n_checks = 0;
    int                n_pass = 0;
    int                n_cyc = 0;

    mem_req_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .STARVE_LIMIT(16), .WAIT_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_en(in_rd_en), .in_wr_en(in_wr_en), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_en(out_rd_en), .out_wr_en(out_wr_en), .out_addr(out_addr),
        .out_src(out_src), .out_req_id(out_req_id), .req_fire(req_fire),
        .global_cycle(global_cycle), .err_drop_cnt(err_drop_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_cyc++;
    endtask

    task automatic set_req(input int p, input logic rd, input logic wr, input logic [AW-1:0] a);
        in_valid[p]        = 1'b1;
        in_rd_en[p]        = rd;
        in_wr_en[p]        = wr;
        in_addr[p*AW +: AW] = a;
    endtask

    task automatic push_exp(input int src, input logic rd, input logic wr, input logic [AW-1:0] a);
        exp_q.push_back({SW'(src), rd, wr, a, exp_id});
        exp_id = exp_id + 32'd1;
    endtask

    // Scoreboard monitor: every downstream fire must match the queue head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_fire: got src %0d addr 0x%0h, required no request", out_src, out_addr);
            end else begin
                e = exp_q.pop_front();
                check("fire_strobe", 64'(req_fire), 64'd1);
                check("fire_src",    64'(out_src),    64'(e[W-1 -: SW]));
                check("fire_rd",     64'(out_rd_en),  64'(e[65]));
                check("fire_wr",     64'(out_wr_en),  64'(e[64]));
                check("fire_addr",   64'(out_addr),   64'(e[63:32]));
                check("fire_id",     64'(out_req_id), 64'(e[31:0]));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_rd_en  = '0;
        in_wr_en  = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_rd_wr", 64'({out_rd_en, out_wr_en}), 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        check("rst_req_id", 64'(out_req_id), 64'd0);
        check("rst_cycle", global_cycle, 64'd0);
        check("rst_err", 64'(err_drop_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        n_cyc = 0;

        // Single read from port 0
        set_req(0, 1'b1, 1'b0, 32'h0000_1000);
        #1;
        check("single_ready", 64'(in_ready), 64'b0001);
        push_exp(0, 1'b1, 1'b0, 32'h0000_1000);
        step();
        in_valid = '0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_id0", 64'(out_req_id), 64'd0);
        step();
        check("single_id1", 64'(out_req_id), 64'd1);
        check("single_empty", 64'(out_valid), 64'd0);

        // All ports valid: rotation starts after port 0, one grant per cycle
        for (int p = 0; p < NP; p++) set_req(p, (p % 2) == 0, (p % 2) != 0, 32'h0000_2000 + p);
        #1;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = (1 + k) % NP;
            check("rr_grant", 64'(in_ready), 64'(1) << g);
            push_exp(g, (g % 2) == 0, (g % 2) != 0, 32'h0000_2000 + g);
            step();
        end
        in_valid = '0;
        step();

        // Stall with port 2 held; ports 1 and 3 age past the starvation limit
        out_ready = 1'b0;
        set_req(2, 1'b1, 1'b0, 32'h0000_3200);
        #1;
        check("stall_load_ready", 64'(in_ready), 64'b0100);
        push_exp(2, 1'b1, 1'b0, 32'h0000_3200);
        step();
        in_valid = '0;
        set_req(1, 1'b1, 1'b0, 32'h0000_3100);
        set_req(3, 1'b0, 1'b1, 32'h0000_3300);
        for (int k = 0; k < 20; k++) begin
            check("stall_ready", 64'(in_ready), 64'd0);
            check("stall_src", 64'(out_src), 64'd2);
            check("stall_addr", 64'(out_addr), 64'h3200);
            check("stall_nofire", 64'(req_fire), 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("starve_grant_low", 64'(in_ready), 64'b0010);
        push_exp(1, 1'b1, 1'b0, 32'h0000_3100);
        step();
        in_valid[1] = 1'b0;
        check("starve_grant_next", 64'(in_ready), 64'b1000);
        push_exp(3, 1'b0, 1'b1, 32'h0000_3300);
        step();
        in_valid = '0;
        step();

        // Malformed requests are consumed and counted
        set_req(2, 1'b1, 1'b1, 32'h0000_4200);
        set_req(3, 1'b1, 1'b0, 32'h0000_4300);
        #1;
        check("bad_ready", 64'(in_ready), 64'b0100);
        step();
        in_valid[2] = 1'b0;
        check("bad_no_valid", 64'(out_valid), 64'd0);
        check("bad_err1", 64'(err_drop_cnt), 64'd1);
        check("bad_next_grant", 64'(in_ready), 64'b1000);
        push_exp(3, 1'b1, 1'b0, 32'h0000_4300);
        step();
        in_valid = '0;
        set_req(1, 1'b0, 1'b0, 32'h0000_4100);
        #1;
        check("bad2_ready", 64'(in_ready), 64'b0010);
        step();
        in_valid = '0;
        check("bad2_empty", 64'(out_valid), 64'd0);
        check("bad_err2", 64'(err_drop_cnt), 64'd2);

        // Request ID wrap
        force dut.r_req_id = 32'hFFFF_FFFF;
        #1;
        release dut.r_req_id;
        exp_id = 32'hFFFF_FFFF;
        set_req(0, 1'b0, 1'b1, 32'h0000_5000);
        #1;
        push_exp(0, 1'b0, 1'b1, 32'h0000_5000);
        step();
        in_valid = '0;
        check("wrap_id_shown", 64'(out_req_id), 64'hFFFF_FFFF);
        step();
        check("wrap_id_zero", 64'(out_req_id), 64'd0);
        check("cycle_count", global_cycle, 64'(n_cyc));

        // Asynchronous reset mid-cycle with a request held
        out_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_6000);
        step();
        in_valid = '0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_id", 64'(out_req_id), 64'd0);
        check("arst_cycle", global_cycle, 64'd0);
        check("arst_err", 64'(err_drop_cnt), 64'd0);
        check("arst_addr", 64'(out_addr), 64'd0);
        exp_id = '0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cyc = 0;
        step();
        check("post_rst_empty", 64'(out_valid), 64'd0);
        step();
        check("post_rst_id", 64'(out_req_id), 64'd0);
        check("post_rst_cycle", global_cycle, 64'(n_cyc));

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
